seven_segment_multi_counter: RTL and testbench
==============================================

Name: seven_segment_multi_counter

Overview:
- Parametrised successor to the single-digit seconds counter.
- Drives NUM_DIGITS BCD digits with an up/down count, a runtime-selectable tick period, and a time-multiplexed 7-segment scan.
- Sits between the top-level pin wrapper (ui_in, uo_out, uio_*) and the display.
- Exposes the packed BCD value for the bidirectional GPIO.

Parameters:
- NUM_DIGITS, 4, number of BCD digits (1..8).
- MAX_COUNT, 24'd10_000_000, default prescaler compare value when compare_in==0; must be >=1.
- SCAN_DIV, 16'd10_000, clk cycles each digit stays selected; must be >=1.

Ports:
- clk  in  1  system clock (10 MHz on board).
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design enable; when low, prescaler, digits and scan all hold.
- count_en  in  1  run/pause; when low, prescaler and digits hold, scan continues.
- up_dn  in  1  1=count up, 0=count down.
- clear  in  1  synchronous clear of prescaler and digits.
- compare_in  in  8  0 selects MAX_COUNT; nonzero selects compare={6'b0,compare_in,10'b0}.
- seg_out  out  7  segments {g,f,e,d,c,b,a}, active high, for the selected digit.
- digit_sel  out  NUM_DIGITS  one-hot active-high digit enable; bit0 = least significant digit.
- value_out  out  4*NUM_DIGITS  packed BCD value; digit 0 in [3:0].
- tick_out  out  1  one-cycle pulse per count step.
- carry_out  out  1  one-cycle pulse on wrap (up) or borrow (down).

Behaviour:
- Reset: while rst_n=0 all registers and outputs are 0, including seg_out, digit_sel, value_out, tick_out and carry_out; scan index = 0. Reset takes effect asynchronously, mid-count included.
- Prescaler (24 bit):
  - Advances only when ena & count_en.
  - When prescaler >= compare: prescaler<=0 and a step occurs. Tick period is compare+1 cycles.
  - The >= comparison means lowering compare_in below the current prescaler value forces a step on the next enabled cycle; there is no 2^24 run-out.
- Step (registered):
  - tick_out=1 for exactly one cycle.
  - Up: digit0+1; any digit passing 9 becomes 0 and carries into the next digit. All-9s -> all-0s with carry_out=1 in the same cycle as tick_out.
  - Down: digit0-1; any digit passing 0 becomes 9 and borrows from the next digit. All-0s -> all-9s with carry_out=1.
  - up_dn is sampled in the step cycle.
- clear=1 (with ena=1):
  - Next edge sets prescaler=0 and digits=0.
  - Overrides a coincident step; tick_out and carry_out stay 0.
- ena=0 overrides clear and count_en: everything holds.
- Scan:
  - A 16-bit scan counter counts 0..SCAN_DIV-1 independent of count_en.
  - On wrap, scan index increments modulo NUM_DIGITS.
- Outputs:
  - digit_sel = 1<<index.
  - seg_out = decode(selected digit).
  - Both are registered with 1-cycle latency from index/value; value_out is a direct register.
- Decode, hex 0-9: 3F,06,5B,4F,66,6D,7D,07,7F,6F. Any BCD value >9 (unreachable) decodes to 00.
- Digits remain valid BCD at all times.

Optional Feature:
- Macro: SEVEN_SEGMENT_BLANK_LEADING_ZERO_EN.
- Defined: seg_out=00 for any digit above digit 0 that is zero and whose more-significant digits are all zero. digit_sel still scans. Example: value 0042 shows blank, blank, 4, 2.
- Undefined: all digits are always decoded, including leading zeros.

Test Plan:
- Reset and scan start (NUM_DIGITS=2, MAX_COUNT=3, SCAN_DIV=2):
  - Drop rst_n mid-count -> all outputs 0 immediately.
  - Release -> one cycle later digit_sel=01 and seg_out=3F.
  - digit_sel toggles 01/10 every 2 cycles.
- Up count: count_en=1, up_dn=1, compare_in=0 -> tick_out every 4 cycles; after 10 ticks value_out=8'h10 and carry_out has stayed 0.
- Up wrap: from value 8'h99, one step -> value 8'h00, with tick_out and carry_out both high for the same single cycle.
- Down borrow: from 8'h10, two steps (up_dn=0) -> 8'h09 then 8'h08; from 8'h00, one step -> 8'h99 with carry_out=1.
- Compare select:
  - compare_in=1 -> tick period 1025 cycles.
  - Switch compare_in 1->0 (MAX_COUNT=3) while prescaler=500 -> tick on the next cycle.
- Holds and clear:
  - clear and step coincident -> value 0, tick_out=0.
  - count_en=0 -> value frozen while digit_sel keeps scanning.
  - ena=0 -> digit_sel frozen.
  - With SEVEN_SEGMENT_BLANK_LEADING_ZERO_EN and value 8'h05 -> seg_out=00 when digit_sel=10, and 6D when digit_sel=01.

Source files
------------

// File: rtl/seven_segment_multi_counter.sv
// seven_segment_multi_counter
// NUM_DIGITS-digit BCD up/down counter with a runtime-selectable tick period
// and a time-multiplexed, active-high 7-segment scan.
// Optional build macro: SEVEN_SEGMENT_BLANK_LEADING_ZERO_EN blanks leading
// zero digits above digit 0 while the digit enables keep scanning.
module seven_segment_multi_counter #(
    parameter int          NUM_DIGITS = 4,
    parameter logic [23:0] MAX_COUNT  = 24'd10_000_000,
    parameter logic [15:0] SCAN_DIV   = 16'd10_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    count_en,
    input  logic                    up_dn,
    input  logic                    clear,
    input  logic [7:0]              compare_in,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [4*NUM_DIGITS-1:0] value_out,
    output logic                    tick_out,
    output logic                    carry_out
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [23:0]             prescaler_q, prescaler_d;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic                    tick_q, tick_d;
    logic                    carry_q, carry_d;
    logic [15:0]             scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
    logic [6:0]              seg_q, seg_d;

    logic [23:0]             compare;
    logic                    at_compare;
    logic [4*NUM_DIGITS-1:0] value_stepped;
    logic                    wrap;
    logic [3:0]              sel_digit;
    logic [6:0]              sel_decoded;
`ifdef SEVEN_SEGMENT_BLANK_LEADING_ZERO_EN
    logic                    lead_zero;
    logic                    blank_sel;
`endif

    function automatic logic [6:0] decode_bcd(input logic [3:0] d);
        case (d)
            4'd0:    decode_bcd = 7'h3F;
            4'd1:    decode_bcd = 7'h06;
            4'd2:    decode_bcd = 7'h5B;
            4'd3:    decode_bcd = 7'h4F;
            4'd4:    decode_bcd = 7'h66;
            4'd5:    decode_bcd = 7'h6D;
            4'd6:    decode_bcd = 7'h7D;
            4'd7:    decode_bcd = 7'h07;
            4'd8:    decode_bcd = 7'h7F;
            4'd9:    decode_bcd = 7'h6F;
            default: decode_bcd = 7'h00;
        endcase
    endfunction

    // Pick the active compare value; >= lets a lowered compare fire at once
    always_comb begin
        compare    = (compare_in == 8'd0) ? MAX_COUNT : {6'b0, compare_in, 10'b0};
        at_compare = (prescaler_q >= compare);
    end

    // Ripple the BCD increment/decrement; wrap stays set only if every digit rolled over
    always_comb begin
        value_stepped = value_q;
        wrap          = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wrap) begin
                if (up_dn) begin
                    if (value_q[4*i +: 4] >= 4'd9) begin
                        value_stepped[4*i +: 4] = 4'd0;
                    end else begin
                        value_stepped[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
                        wrap                    = 1'b0;
                    end
                end else begin
                    if (value_q[4*i +: 4] == 4'd0) begin
                        value_stepped[4*i +: 4] = 4'd9;
                    end else begin
                        value_stepped[4*i +: 4] = value_q[4*i +: 4] - 4'd1;
                        wrap                    = 1'b0;
                    end
                end
            end
        end
    end

    // Prescaler and digits: ena gates everything, clear beats a coincident step
    always_comb begin
        prescaler_d = prescaler_q;
        value_d     = value_q;
        tick_d      = 1'b0;
        carry_d     = 1'b0;
        if (ena) begin
            if (clear) begin
                prescaler_d = 24'd0;
                value_d     = '0;
            end else if (count_en) begin
                if (at_compare) begin
                    prescaler_d = 24'd0;
                    value_d     = value_stepped;
                    tick_d      = 1'b1;
                    carry_d     = wrap;
                end else begin
                    prescaler_d = prescaler_q + 24'd1;
                end
            end
        end
    end

    // Scan timer keeps running while paused; only ena stops it
    always_comb begin
        scan_cnt_d = scan_cnt_q;
        scan_idx_d = scan_idx_q;
        if (ena) begin
            if (scan_cnt_q >= SCAN_DIV - 16'd1) begin
                scan_cnt_d = 16'd0;
                scan_idx_d = (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0
                                                                     : scan_idx_q + IDX_W'(1);
            end else begin
                scan_cnt_d = scan_cnt_q + 16'd1;
            end
        end
    end

    // Select and decode the digit currently addressed by the scan index
    always_comb begin
        sel_digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx_q == IDX_W'(i)) begin
                sel_digit = value_q[4*i +: 4];
            end
        end
        sel_decoded = decode_bcd(sel_digit);
    end

`ifdef SEVEN_SEGMENT_BLANK_LEADING_ZERO_EN
    // Walk down from the top digit; a digit is blank while it and everything above are zero
    always_comb begin
        lead_zero = 1'b1;
        blank_sel = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lead_zero = lead_zero && (value_q[4*i +: 4] == 4'd0);
            if (scan_idx_q == IDX_W'(i)) begin
                blank_sel = lead_zero;
            end
        end
    end
`endif

    // Register the one-hot enable and segment pattern together so they stay aligned
    always_comb begin
        digit_sel_d = digit_sel_q;
        seg_d       = seg_q;
        if (ena) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_sel_d[i] = (scan_idx_q == IDX_W'(i));
            end
`ifdef SEVEN_SEGMENT_BLANK_LEADING_ZERO_EN
            seg_d = blank_sel ? 7'h00 : sel_decoded;
`else
            seg_d = sel_decoded;
`endif
        end
    end

    // State registers with asynchronous clear to all-zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q <= 24'd0;
            value_q     <= '0;
            tick_q      <= 1'b0;
            carry_q     <= 1'b0;
            scan_cnt_q  <= 16'd0;
            scan_idx_q  <= '0;
            digit_sel_q <= '0;
            seg_q       <= 7'h00;
        end else begin
            prescaler_q <= prescaler_d;
            value_q     <= value_d;
            tick_q      <= tick_d;
            carry_q     <= carry_d;
            scan_cnt_q  <= scan_cnt_d;
            scan_idx_q  <= scan_idx_d;
            digit_sel_q <= digit_sel_d;
            seg_q       <= seg_d;
        end
    end

    assign seg_out   = seg_q;
    assign digit_sel = digit_sel_q;
    assign value_out = value_q;
    assign tick_out  = tick_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_seven_segment_multi_counter.sv
// Directed testbench for seven_segment_multi_counter with NUM_DIGITS=2,
// MAX_COUNT=3 (tick every 4 cycles) and SCAN_DIV=2 (digit swap every 2 cycles).
module tb_seven_segment_multi_counter;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       count_en;
    logic       up_dn;
    logic       clear;
    logic [7:0] compare_in;
    logic [6:0] seg_out;
    logic [1:0] digit_sel;
    logic [7:0] value_out;
    logic       tick_out;
    logic       carry_out;

    int checkCount;
    int errorCount;
    int scanEdges;

    seven_segment_multi_counter #(
        .NUM_DIGITS(2),
        .MAX_COUNT (24'd3),
        .SCAN_DIV  (16'd2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .count_en  (count_en),
        .up_dn     (up_dn),
        .clear     (clear),
        .compare_in(compare_in),
        .seg_out   (seg_out),
        .digit_sel (digit_sel),
        .value_out (value_out),
        .tick_out  (tick_out),
        .carry_out (carry_out)
    );

    // 10 ns clock; the bench drives and samples on the falling edge
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference scan model: number of enabled rising edges since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) scanEdges <= 0;
        else if (ena) scanEdges <= scanEdges + 1;
    end

    function automatic logic [1:0] expSel(input int e);
        if (e == 0) return 2'b00;
        return ((((e - 1) / 2) % 2) == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [6:0] segModel(input logic [7:0] v, input logic [1:0] sel);
        logic [3:0] d;
        logic [6:0] t;
        if (sel == 2'b00) return 7'h00;
        d = (sel == 2'b10) ? v[7:4] : v[3:0];
        case (d)
            4'd0: t = 7'h3F;  4'd1: t = 7'h06;  4'd2: t = 7'h5B;  4'd3: t = 7'h4F;
            4'd4: t = 7'h66;  4'd5: t = 7'h6D;  4'd6: t = 7'h7D;  4'd7: t = 7'h07;
            4'd8: t = 7'h7F;  4'd9: t = 7'h6F;  default: t = 7'h00;
        endcase
`ifdef SEVEN_SEGMENT_BLANK_LEADING_ZERO_EN
        if (sel == 2'b10 && v[7:4] == 4'd0) t = 7'h00;
`endif
        return t;
    endfunction

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic ce, input logic ud,
                                 input logic clr, input logic [7:0] cmp);
        ena        = e;
        count_en   = ce;
        up_dn      = ud;
        clear      = clr;
        compare_in = cmp;
    endtask

    // Wait for nTicks tick pulses, bounded by budget cycles per tick
    task automatic runTicks(input int nTicks, input int budget, output int gap,
                            output logic sawCarry, output logic timedOut);
        int seen;
        int since;
        seen = 0; since = 0; gap = 0; sawCarry = 1'b0; timedOut = 1'b0;
        while (seen < nTicks) begin
            @(negedge clk);
            since++;
            if (carry_out) sawCarry = 1'b1;
            if (tick_out) begin
                seen++;
                gap   = since;
                since = 0;
            end else if (since > budget) begin
                timedOut = 1'b1;
                break;
            end
        end
    endtask

    int   gap;
    logic sawCarry;
    logic timedOut;

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Count a little, then drop reset between clock edges
        runTicks(2, 20, gap, sawCarry, timedOut);
        checkOutput("pre_reset_timeout", 32'(timedOut), 32'd0);
        checkOutput("pre_reset_value", 32'(value_out), 32'h02);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_value", 32'(value_out), 32'h00);
        checkOutput("rst_digit_sel", 32'(digit_sel), 32'h0);
        checkOutput("rst_seg", 32'(seg_out), 32'h00);
        checkOutput("rst_tick", 32'(tick_out), 32'd0);
        checkOutput("rst_carry", 32'(carry_out), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);

        // Release and follow the scan for a few cycles
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("scan_sel", 32'(digit_sel), 32'(expSel(scanEdges)));
            checkOutput("scan_seg", 32'(seg_out), 32'(segModel(8'h00, expSel(scanEdges))));
        end
        checkOutput("scan_first_sel", 32'(expSel(1)), 32'h1);

        // Up count from a clean state
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'd0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        runTicks(10, 20, gap, sawCarry, timedOut);
        checkOutput("up_timeout", 32'(timedOut), 32'd0);
        checkOutput("up_period", 32'(gap), 32'd4);
        checkOutput("up_value", 32'(value_out), 32'h10);
        checkOutput("up_no_carry", 32'(sawCarry), 32'd0);

        // Down count with borrow, then underflow to 99
        up_dn = 1'b0;
        runTicks(1, 20, gap, sawCarry, timedOut);
        checkOutput("down_09", 32'(value_out), 32'h09);
        runTicks(1, 20, gap, sawCarry, timedOut);
        checkOutput("down_08", 32'(value_out), 32'h08);
        runTicks(8, 20, gap, sawCarry, timedOut);
        checkOutput("down_00", 32'(value_out), 32'h00);
        checkOutput("down_no_carry", 32'(sawCarry), 32'd0);
        runTicks(1, 20, gap, sawCarry, timedOut);
        checkOutput("down_timeout", 32'(timedOut), 32'd0);
        checkOutput("down_99", 32'(value_out), 32'h99);
        checkOutput("down_carry", 32'(carry_out), 32'd1);
        checkOutput("down_tick", 32'(tick_out), 32'd1);
        @(negedge clk);
        checkOutput("down_carry_pulse", 32'(carry_out), 32'd0);
        checkOutput("down_tick_pulse", 32'(tick_out), 32'd0);

        // Up wrap 99 -> 00
        up_dn = 1'b1;
        runTicks(1, 20, gap, sawCarry, timedOut);
        checkOutput("wrap_value", 32'(value_out), 32'h00);
        checkOutput("wrap_carry", 32'(carry_out), 32'd1);
        checkOutput("wrap_tick", 32'(tick_out), 32'd1);

        // compare_in=1 gives 1024 compare, 1025-cycle period
        compare_in = 8'd1;
        runTicks(2, 1100, gap, sawCarry, timedOut);
        checkOutput("cmp1_timeout", 32'(timedOut), 32'd0);
        checkOutput("cmp1_period", 32'(gap), 32'd1025);
        checkOutput("cmp1_value", 32'(value_out), 32'h02);

        // Lowering compare below the prescaler forces the next step
        repeat (500) @(negedge clk);
        checkOutput("cmp_drop_before", 32'(tick_out), 32'd0);
        compare_in = 8'd0;
        @(negedge clk);
        checkOutput("cmp_drop_tick", 32'(tick_out), 32'd1);
        checkOutput("cmp_drop_value", 32'(value_out), 32'h03);

        // Clear lands on the same edge a step would occur
        repeat (3) @(negedge clk);
        checkOutput("clr_before", 32'(value_out), 32'h03);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checkOutput("clr_value", 32'(value_out), 32'h00);
        checkOutput("clr_tick", 32'(tick_out), 32'd0);
        checkOutput("clr_carry", 32'(carry_out), 32'd0);

        // Pause: value frozen, scan continues, segment pattern follows digit
        runTicks(5, 20, gap, sawCarry, timedOut);
        checkOutput("pause_setup", 32'(value_out), 32'h05);
        count_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("pause_value", 32'(value_out), 32'h05);
            checkOutput("pause_tick", 32'(tick_out), 32'd0);
            checkOutput("pause_sel", 32'(digit_sel), 32'(expSel(scanEdges)));
            checkOutput("pause_seg", 32'(seg_out), 32'(segModel(8'h05, expSel(scanEdges))));
        end

        // ena low overrides count_en and clear
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("hold_value", 32'(value_out), 32'h05);
            checkOutput("hold_sel", 32'(digit_sel), 32'(expSel(scanEdges)));
        end

        // Prescaler also held, so the next step is a full period away
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        runTicks(1, 20, gap, sawCarry, timedOut);
        checkOutput("resume_timeout", 32'(timedOut), 32'd0);
        checkOutput("resume_period", 32'(gap), 32'd4);
        checkOutput("resume_value", 32'(value_out), 32'h06);
        checkOutput("resume_sel", 32'(digit_sel), 32'(expSel(scanEdges)));

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
